// File: rtl/vga_scroll_sequencer.sv
// Frame-rate scroll controller: detects the vsync frame edge in the pixel clock
// domain and steps a 4-scene x/y scroll schedule once per frame.
module vga_scroll_sequencer #(
  parameter int OFS_W            = 10,
  parameter int SCROLL_FRAMES    = 120,
  parameter int HOLD_FRAMES      = 30,
  parameter int Y_WRAP           = 480,
  parameter bit VSYNC_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_in,
  input  logic             run_en,
  input  logic             step,
  input  logic [2:0]       speed,
  output logic [OFS_W-1:0] x_offset,
  output logic [OFS_W-1:0] y_offset,
  output logic [1:0]       scene,
  output logic             frame_tick
);

  localparam int MAX_FRAMES = (SCROLL_FRAMES > HOLD_FRAMES) ? SCROLL_FRAMES : HOLD_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  typedef enum logic [1:0] {SCROLL_X, HOLD_A, SCROLL_Y, HOLD_B} scene_t;

  scene_t           scene_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             vs_q;        // previous vsync, normalised to 1 = asserted
  logic             step_q;
  logic             step_armed;

  logic             vs_act;
  logic             frame_edge;
  logic             step_rise;
  logic             adv;
  logic             last_frame;
  logic [OFS_W:0]   y_sum;
  logic [OFS_W-1:0] y_next;
  logic [OFS_W-1:0] x_next;

  assign vs_act     = VSYNC_ACTIVE_LOW ? ~vsync_in : vsync_in;
  assign frame_edge = vs_act & ~vs_q;
  assign step_rise  = step & ~step_q;
  assign adv        = run_en | step_armed | step_rise;

  // Scroll scenes have even encodings, hold scenes odd.
  assign last_frame = scene_q[0] ? (frame_cnt == CNT_W'(HOLD_FRAMES - 1))
                                 : (frame_cnt == CNT_W'(SCROLL_FRAMES - 1));

  assign x_next = x_offset + OFS_W'(speed);
  assign y_sum  = {1'b0, y_offset} + (OFS_W+1)'(speed);
  assign y_next = (y_sum >= (OFS_W+1)'(Y_WRAP)) ? OFS_W'(y_sum - (OFS_W+1)'(Y_WRAP))
                                                : OFS_W'(y_sum);

  assign scene = scene_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_offset   <= '0;
      y_offset   <= '0;
      scene_q    <= SCROLL_X;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      step_armed <= 1'b0;
      step_q     <= 1'b1;
      vs_q       <= 1'b1;
    end else begin
      vs_q       <= vs_act;
      step_q     <= step;
      frame_tick <= frame_edge;
      if (frame_edge) begin
        step_armed <= 1'b0;
        if (adv) begin
          case (scene_q)
            SCROLL_X: x_offset <= x_next;
            SCROLL_Y: y_offset <= y_next;
            default: ;
          endcase
          if (last_frame) begin
            frame_cnt <= '0;
            scene_q   <= scene_t'(scene_q + 2'd1);
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end else if (step_rise && !run_en) begin
        step_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_scroll_sequencer.sv
// Directed bench for vga_scroll_sequencer: a short-schedule instance for most
// scenarios plus a long-schedule instance for the offset wrap cases.
module tb_vga_scroll_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n, vsync_in, run_en, step;
  logic [2:0] speed;
  logic [9:0] x_offset, y_offset, x2, y2;
  logic [1:0] scene, sc2;
  logic       frame_tick, tk2;

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  int t0;

  always #5 clk = ~clk;

  vga_scroll_sequencer #(.OFS_W(10), .SCROLL_FRAMES(4), .HOLD_FRAMES(2), .Y_WRAP(480),
                         .VSYNC_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .run_en(run_en), .step(step),
    .speed(speed), .x_offset(x_offset), .y_offset(y_offset), .scene(scene),
    .frame_tick(frame_tick));

  vga_scroll_sequencer #(.OFS_W(10), .SCROLL_FRAMES(200), .HOLD_FRAMES(2), .Y_WRAP(480),
                         .VSYNC_ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .vsync_in(vsync_in), .run_en(run_en), .step(step),
    .speed(speed), .x_offset(x2), .y_offset(y2), .scene(sc2), .frame_tick(tk2));

  always @(negedge clk) if (frame_tick) ticks++;

  typedef struct {
    logic       run;
    logic [2:0] spd;
    int         x;
    int         y;
    int         sc;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where the new frame is visible.
  task automatic frame_start();
    vsync_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_end();
    vsync_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame();
    frame_start();
    frame_end();
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      run_en = vt[i].run;
      speed  = vt[i].spd;
      frame_start();
      chk($sformatf("row%0d_tick", i), frame_tick, 1);
      chk($sformatf("row%0d_x", i), x_offset, vt[i].x);
      chk($sformatf("row%0d_y", i), y_offset, vt[i].y);
      chk($sformatf("row%0d_scene", i), scene, vt[i].sc);
      frame_end();
      chk($sformatf("row%0d_tick_len", i), frame_tick, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 3'd3, 3,  0, 0};
    vt[1]  = '{1'b1, 3'd3, 6,  0, 0};
    vt[2]  = '{1'b1, 3'd3, 9,  0, 0};
    vt[3]  = '{1'b1, 3'd3, 12, 0, 1};
    vt[4]  = '{1'b1, 3'd3, 12, 0, 1};
    vt[5]  = '{1'b1, 3'd3, 12, 0, 2};
    for (int i = 6; i <= 10; i++) vt[i] = '{1'b0, 3'd5, 0, 0, 0};

    rst_n = 1'b0; rst2_n = 1'b0; vsync_in = 1'b0;
    run_en = 1'b0; step = 1'b0; speed = 3'd0;
    @(negedge clk);

    // reset holds everything at zero while vsync toggles
    for (int i = 0; i < 3; i++) begin
      vsync_in = ~vsync_in;
      @(negedge clk);
      chk("rst_x", x_offset, 0);
      chk("rst_y", y_offset, 0);
      chk("rst_scene", scene, 0);
      chk("rst_tick", frame_tick, 0);
    end
    // release with vsync already asserted: no tick
    vsync_in = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    chk("release_tick0", frame_tick, 0);
    @(negedge clk);
    chk("release_tick1", frame_tick, 0);
    frame_end();

    // scroll X at speed 3 through HOLD_A into SCROLL_Y
    run_rows(0, 5);

    // long schedule: x wrap at 1024 and y wrap at 480
    rst_n = 1'b0; rst2_n = 1'b1; run_en = 1'b1; speed = 3'd7;
    @(negedge clk);
    repeat (147) frame();
    chk("long_x_wrap", x2, 5);
    chk("long_scene0", sc2, 0);
    repeat (55) frame();
    chk("long_scene2", sc2, 2);
    chk("long_x_hold", x2, 376);
    repeat (68) frame();
    chk("long_y476", y2, 476);
    frame_start();
    chk("long_y_wrap", y2, 3);
    chk("long_tick", tk2, 1);
    frame_end();
    rst2_n = 1'b0;

    // frozen: ticks continue, state holds
    rst_n = 1'b1; run_en = 1'b0;
    @(negedge clk);
    t0 = ticks;
    run_rows(6, 10);
    chk("frozen_ticks", ticks - t0, 5);
    // two step pulses give one advance
    step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
    step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
    frame_start();
    chk("step_adv_x", x_offset, 5);
    frame_end();
    frame_start();
    chk("step_refrozen_x", x_offset, 5);
    chk("step_refrozen_tick", frame_tick, 1);
    frame_end();

    // step rising on the edge cycle itself
    step = 1'b1;
    frame_start();
    chk("step_on_edge_x", x_offset, 10);
    frame_end();
    step = 1'b0;
    @(negedge clk);
    // step while running is not armed
    run_en = 1'b1;
    step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
    run_en = 1'b0;
    frame_start();
    chk("step_run_ignored_x", x_offset, 10);
    chk("step_run_ignored_scene", scene, 0);
    frame_end();

    // reach SCROLL_Y with frame_cnt=2, then reset over an edge and a step
    run_en = 1'b1; speed = 3'd5;
    frame(); frame();
    chk("pre6_scene1", scene, 1);
    chk("pre6_x", x_offset, 20);
    frame(); frame();
    speed = 3'd7;
    frame(); frame();
    chk("pre6_scene2", scene, 2);
    chk("pre6_y", y_offset, 14);
    rst_n = 1'b0; step = 1'b1;
    frame_start();
    chk("midrst_x", x_offset, 0);
    chk("midrst_y", y_offset, 0);
    chk("midrst_scene", scene, 0);
    chk("midrst_tick", frame_tick, 0);
    rst_n = 1'b1; step = 1'b0;
    @(negedge clk);
    chk("midrst_release_tick", frame_tick, 0);
    frame_end();
    frame_start();
    chk("restart_tick", frame_tick, 1);
    chk("restart_x", x_offset, 7);
    chk("restart_scene", scene, 0);
    frame_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
